// File: rtl/oam_dma.sv
// oam_dma
//    OAM DMA controller and bus arbiter between the CPU core and the memory map.
//    A CPU store to 0xFF46 latches a source page and copies 160 bytes from
//    {src, 8'h00}..{src, 8'h9F} into OAM at 0xFE00..0xFE9F, one byte every three
//    cycles (READ, CAPTURE, WRITE). While the copy runs the DMA owns the shared
//    bus. The CPU may still reach HRAM and the DMA register; everything else it
//    tries is blocked.
//
// Ports
//    clockgb      in   1   system clock, all state on rising edge
//    resetn       in   1   asynchronous active-low reset
//    cpu_address  in  16   CPU bus address
//    cpu_indata   in   8   CPU store data
//    cpu_outdata  out  8   load data returned to the CPU (one cycle after the load)
//    cpu_load     in   1   CPU read strobe
//    cpu_store    in   1   CPU write strobe
//    bus_address  out 16   address to the memory map
//    bus_indata   out  8   store data to the memory map
//    bus_outdata  in   8   memory map read data, valid the cycle after bus_load
//    bus_load     out  1   read strobe to the memory map
//    bus_store    out  1   write strobe to the memory map
//    busy         out  1   high while a transfer is in progress
module oam_dma (
   input  logic        clockgb,
   input  logic        resetn,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_indata,
   output logic [7:0]  cpu_outdata,
   input  logic        cpu_load,
   input  logic        cpu_store,
   output logic [15:0] bus_address,
   output logic [7:0]  bus_indata,
   input  logic [7:0]  bus_outdata,
   output logic        bus_load,
   output logic        bus_store,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

   // Source of the byte handed back to the CPU in the cycle after a load.
   // RET_ZERO only exists so the output sits at 8'h00 straight out of reset.
   typedef enum logic [1:0] {RET_ZERO, RET_BUS, RET_BLOCKED, RET_SRC} ret_sel_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] HRAM_LO      = 16'hFF80;
   localparam logic [15:0] HRAM_HI      = 16'hFFFE;
   localparam logic [7:0]  LAST_IDX     = 8'd159;
   localparam logic [7:0]  OAM_PAGE     = 8'hFE;

   state_t     state, state_next;
   ret_sel_t   ret_sel, ret_sel_next;
   logic [7:0] dma_src;
   logic [7:0] src_eff;
   logic [7:0] idx, idx_next;
   logic [7:0] dma_data;
   logic       hit_reg;
   logic       hit_hram;
   logic       cpu_access;
   logic       restart;
   logic       hram_grant;
   logic       blocked;
   logic       stall;

   // Address decode and arbitration terms. A store to 0xFF46 is both the
   // initial start and the restart; it always wins over the current step.
   assign hit_reg    = (cpu_address == DMA_REG_ADDR);
   assign hit_hram   = (cpu_address >= HRAM_LO) && (cpu_address <= HRAM_HI);
   assign cpu_access = cpu_load | cpu_store;
   assign restart    = cpu_store & hit_reg;
   assign busy       = (state != IDLE);
   assign hram_grant = busy & cpu_access & hit_hram;
   assign blocked    = busy & cpu_access & ~hit_hram & ~hit_reg;
   assign stall      = hram_grant & ((state == READ) | (state == WRITE));

   // Pages at 0xE0 and above are echo RAM, so fold them down onto work RAM.
   assign src_eff = (dma_src >= 8'hE0) ? (dma_src - 8'h20) : dma_src;

   // Next-state logic for the copy engine. A granted HRAM access in READ or
   // WRITE holds the engine in place for a cycle; idx stops at the last byte.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      case (state)
         IDLE: begin
            state_next = IDLE;
         end
         READ: begin
            if (!stall) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            state_next = WRITE;
         end
         WRITE: begin
            if (!stall) begin
               if (idx == LAST_IDX) begin
                  state_next = IDLE;
               end else begin
                  idx_next   = idx + 8'd1;
                  state_next = READ;
               end
            end
         end
      endcase
      if (restart) begin
         state_next = READ;
         idx_next   = 8'd0;
      end
   end

   // Bus mux. When idle the CPU passes straight through, except that the DMA
   // register lives here and is never forwarded. When busy only HRAM accesses
   // reach the bus; otherwise the engine drives its own strobe, and a restart
   // cycle issues nothing so the new page starts cleanly on the following READ.
   always_comb begin
      bus_address = cpu_address;
      bus_indata  = cpu_indata;
      bus_load    = cpu_load & ~hit_reg;
      bus_store   = cpu_store & ~hit_reg;
      if (busy) begin
         bus_load  = hram_grant & cpu_load;
         bus_store = hram_grant & cpu_store;
         if (!restart && !hram_grant) begin
            case (state)
               READ: begin
                  bus_load    = 1'b1;
                  bus_address = {src_eff, idx};
               end
               WRITE: begin
                  bus_store   = 1'b1;
                  bus_address = {OAM_PAGE, idx};
                  bus_indata  = dma_data;
               end
               default: begin
                  bus_load  = hram_grant & cpu_load;
                  bus_store = hram_grant & cpu_store;
               end
            endcase
         end
      end
   end

   // Decide now where next cycle's CPU read data comes from, so the returned
   // byte lines up with bus_outdata arriving one cycle after the strobe.
   always_comb begin
      ret_sel_next = RET_BUS;
      if (cpu_load) begin
         if (blocked) begin
            ret_sel_next = RET_BLOCKED;
         end else if (hit_reg) begin
            ret_sel_next = RET_SRC;
         end
      end
   end

   // Read return mux driven by the registered select.
   always_comb begin
      cpu_outdata = bus_outdata;
      case (ret_sel)
         RET_ZERO:    cpu_outdata = 8'h00;
         RET_BLOCKED: cpu_outdata = 8'hFF;
         RET_SRC:     cpu_outdata = dma_src;
         default:     cpu_outdata = bus_outdata;
      endcase
   end

   // State, counter, source register and the byte in flight. A restart throws
   // away whatever was captured from the old page.
   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         idx      <= 8'd0;
         dma_src  <= 8'h00;
         dma_data <= 8'h00;
         ret_sel  <= RET_ZERO;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         ret_sel <= ret_sel_next;
         if (restart) begin
            dma_src  <= cpu_indata;
            dma_data <= 8'h00;
         end else if (state == CAPTURE) begin
            dma_data <= bus_outdata;
         end
      end
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA controller and bus arbiter between the CPU and the memory map. A CPU store to 0xFF46 starts a 160-byte copy from `{src, 8'h00}`–`{src, 8'h9F}` to 0xFE00–0xFE9F. During the copy the block owns the shared memory-map bus, and CPU accesses are limited to HRAM. It sits between the CPU core and the address decode (`mmap`/`mbc1` side), in series with the `address`/`indata`/`load`/`store` bus.

## Interface

- No parameters.
- `clockgb  in  1`  Game Boy system clock; all state on rising edge.
- `resetn  in  1`  Asynchronous, active-low reset.
- `cpu_address  in  16`  CPU bus address.
- `cpu_indata  in  8`  CPU store data.
- `cpu_outdata  out  8`  Load data returned to the CPU.
- `cpu_load  in  1`  CPU read strobe, one cycle.
- `cpu_store  in  1`  CPU write strobe, one cycle.
- `bus_address  out  16`  Address to the memory map.
- `bus_indata  out  8`  Store data to the memory map.
- `bus_outdata  in  8`  Read data from the memory map; valid the cycle after `bus_load`.
- `bus_load  out  1`  Read strobe to the memory map.
- `bus_store  out  1`  Write strobe to the memory map.
- `busy  out  1`  High while a transfer is in progress.

## Operation

- **Register `dma_src[7:0]` (0xFF46), held here and not forwarded.**
  - A CPU store writes it.
  - A CPU load returns it the next cycle.
- **Effective source page:** `src_eff = (dma_src >= 8'hE0) ? dma_src - 8'h20 : dma_src`. This is the echo-RAM fold.
- **Counter `idx[7:0]`** runs 0..159.
  - Source address = `{src_eff, idx}`.
  - Dest address = `{8'hFE, idx}`.
- **FSM states:** IDLE, READ, CAPTURE, WRITE.
  - IDLE: `busy`=0. The CPU bus is forwarded unchanged.
  - READ: `bus_load`=1, `bus_address`=source. Go to CAPTURE.
  - CAPTURE: DMA does not drive the bus. Latch `dma_data <= bus_outdata`. Go to WRITE.
  - WRITE: `bus_store`=1, `bus_address`=dest, `bus_indata`=`dma_data`.
    - If `idx`==159, go to IDLE.
    - Otherwise `idx <= idx+1` and go to READ.
- **Start:** a CPU store to 0xFF46 in IDLE sets `idx`=0 and goes to READ.
- **Restart:** a CPU store to 0xFF46 while busy loads the new `dma_src`, sets `idx`=0, discards `dma_data` and goes to READ. The new source takes effect from that READ.
- **Arbitration while busy:**
  - HRAM (0xFF80–0xFFFE) and 0xFF46 accesses are always granted.
  - In READ or WRITE, a granted HRAM access owns the bus for that cycle. The DMA stalls: no strobe, same state, same `idx`.
  - In CAPTURE, an HRAM access uses the bus without stalling the DMA.
  - Any other CPU access is blocked:
    - stores are dropped;
    - loads return 8'hFF the following cycle;
    - no bus strobe is issued.
- **CPU read return (registered select):**
  - 8'hFF if the previous cycle's load was blocked.
  - `dma_src` if the previous cycle's load was 0xFF46.
  - Otherwise `bus_outdata`.

## Timing

- **Reset values:**
  - `busy`=0, `cpu_outdata`=8'h00.
  - `bus_address`/`bus_indata`/`bus_load`/`bus_store` follow the CPU inputs, forwarded combinationally (IDLE), with the 0xFF46 exception.
  - `dma_src`=8'h00, `idx`=0, `dma_data`=0, state IDLE.
- **Reset mid-transfer:** aborts immediately. A partial OAM copy remains and no further strobes are issued.
- **Start latency:** a store to 0xFF46 at cycle N gives `busy`=1 and READ at N+1, and the first WRITE at N+3.
- **Unstalled transfer:** 3 cycles/byte, 480 cycles total. `busy` drops the cycle after the last WRITE.
- **Stalls:** each stalled cycle extends the transfer by exactly one cycle.
- **Strobes:** `bus_load`/`bus_store` are never both high. A DMA strobe and a CPU strobe never occur in the same cycle.
- **`idx` wrap:** `idx` never exceeds 159 and is not incremented past it.

## Test plan

- Reset, then store 0xC1 to 0xFF46 with no CPU traffic → 160 writes: 0xFE00..0xFE9F receive data from 0xC100..0xC19F; `busy` high for exactly 480 cycles.
- Mid-transfer CPU load from 0xC000 → 8'hFF returned; no `bus_load` at 0xC000. CPU store to 0x8000 → no `bus_store`.
- CPU load 0xFF90 during each of READ, CAPTURE and WRITE → HRAM data returned.
  - READ and WRITE cases add exactly one cycle to `busy`.
  - CAPTURE case adds none.
  - Copied bytes are unchanged.
- Store 0xE2 to 0xFF46 → source reads at 0xC200..0xC29F.
- Store 0xC1, then 0xD0 at `idx`=40 → restart at `idx` 0 from 0xD000; OAM ends with the 0xD000 page; load of 0xFF46 returns 0xD0.
- Assert `resetn` low at `idx`=80 → `busy`=0 and no strobes next cycle; a later store to 0xFF46 starts cleanly at `idx`=0.
